alu_input_ctrl: RTL and testbench

//  Operand/opcode loader placed directly upstream of the parameterizable ALU on the FPGA board.

---
 rtl/alu_input_ctrl.sv | 141 ++++++++++++++
 tb/tb_alu_input_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_input_ctrl.sv
// ----------------------------------------------------------------------------
// alu_input_ctrl
//   Operand/opcode loader sitting in front of the board ALU. Three push-buttons
//   capture the shared switch bank into the A, B and OP registers that feed the
//   ALU. The ALU's combinational result is registered back out to the LEDs.
//   Every button is synchronized, debounced and rising-edge detected, so one
//   press yields exactly one load.
//
// Ports
//   i_clk         system clock, rising edge
//   i_rst         synchronous reset, active-high
//   i_sw          raw switch bank (used unsynchronized, held static by the user)
//   i_btn_a       raw button, load A
//   i_btn_b       raw button, load B
//   i_btn_op      raw button, load OP
//   i_alu_result  ALU result, combinational from o_data_a/o_data_b/o_op
//   o_data_a      operand A register
//   o_data_b      operand B register
//   o_op          opcode register
//   o_led         registered copy of i_alu_result
//   o_ready       high once A, B and OP have each been loaded since reset
// ----------------------------------------------------------------------------
module alu_input_ctrl #(
    parameter int NB_DATA     = 8,
    parameter int NB_OP       = 6,
    parameter int NB_SW       = 8,
    parameter int DBNC_CYCLES = 1000000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NB_SW-1:0]   i_sw,
    input  logic               i_btn_a,
    input  logic               i_btn_b,
    input  logic               i_btn_op,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_OP-1:0]   o_op,
    output logic [NB_DATA-1:0] o_led,
    output logic               o_ready
);

    localparam int               CNT_W   = $clog2(DBNC_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DBNC_CYCLES - 1);

    typedef enum logic {ST_LOW, ST_HIGH} dbnc_state_t;

    // Bit order everywhere: [0]=A, [1]=B, [2]=OP
    logic [2:0] btn_raw;
    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] level;
    logic [2:0] level_d;
    logic [2:0] strobe;
    logic [2:0] loaded;

    assign btn_raw = {i_btn_op, i_btn_b, i_btn_a};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Debounce FSM per button
    //   state   | meaning
    //   ST_LOW  | debounced level is released
    //   ST_HIGH | debounced level is pressed
    for (genvar g = 0; g < 3; g++) begin : g_dbnc
        dbnc_state_t      state;
        dbnc_state_t      state_nxt;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nxt;
        logic             lvl;

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                state <= ST_LOW;
                cnt   <= '0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
            end
        end

        // The counter only runs while the synced input disagrees with the
        // debounced level; any agreeing cycle restarts the window.
        always_comb begin
            state_nxt = state;
            cnt_nxt   = '0;
            if (sync2[g] != (state == ST_HIGH)) begin
                if (cnt == CNT_MAX) begin
                    state_nxt = (state == ST_HIGH) ? ST_LOW : ST_HIGH;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
        end

        always_comb begin
            lvl = (state == ST_HIGH);
        end

        assign level[g] = lvl;
    end

    // Strobe is registered off the debounced rising edge, so a load lands
    // DBNC_CYCLES+3 edges after the raw button is first sampled high.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            level_d <= '0;
            strobe  <= '0;
        end else begin
            level_d <= level;
            strobe  <= level & ~level_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_data_a <= '0;
            o_data_b <= '0;
            o_op     <= '0;
            o_led    <= '0;
            loaded   <= '0;
        end else begin
            if (strobe[0]) o_data_a <= i_sw[NB_DATA-1:0];
            if (strobe[1]) o_data_b <= i_sw[NB_DATA-1:0];
            if (strobe[2]) o_op     <= i_sw[NB_OP-1:0];
            o_led  <= i_alu_result;
            loaded <= loaded | strobe;
        end
    end

    assign o_ready = &loaded;

endmodule

// File: tb/tb_alu_input_ctrl.sv
module tb_alu_input_ctrl;

    localparam int DBNC = 4;
    localparam int LAT  = DBNC + 3;

    logic       clk;
    logic       rst;
    logic [7:0] sw_drv;
    logic       btn_a;
    logic       btn_b;
    logic       btn_op;
    logic [7:0] alu_result;
    logic [7:0] data_a;
    logic [7:0] data_b;
    logic [5:0] op;
    logic [7:0] led;
    logic       ready;

    int checks = 0;
    int errors = 0;

    alu_input_ctrl #(
        .NB_DATA(8), .NB_OP(6), .NB_SW(8), .DBNC_CYCLES(DBNC)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_sw(sw_drv),
        .i_btn_a(btn_a),
        .i_btn_b(btn_b),
        .i_btn_op(btn_op),
        .i_alu_result(alu_result),
        .o_data_a(data_a),
        .o_data_b(data_b),
        .o_op(op),
        .o_led(led),
        .o_ready(ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Board ALU: used both as the environment and as the golden reference.
    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] opc);
        logic signed [7:0] sa;
        sa = a;
        case (opc)
            6'h20:   return 8'(a + b);
            6'h22:   return 8'(a - b);
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h03:   return sa >>> b;
            6'h02:   return a >> b;
            default: return 8'h00;
        endcase
    endfunction

    assign alu_result = alu_f(data_a, data_b, op);

    // Reference model: a press held >= DBNC cycles loads LAT edges after the
    // first edge that sees it; modelled as a schedule of pending loads.
    typedef struct {
        int         edge_n;
        logic [2:0] mask;
        logic [7:0] sw;
    } load_t;

    load_t      loads[$];
    int         cyc = 0;
    logic [7:0] m_a = 8'h00;
    logic [7:0] m_b = 8'h00;
    logic [5:0] m_op = 6'h00;
    logic [7:0] m_led = 8'h00;
    logic [2:0] m_loaded = 3'b000;
    bit         sb_en = 1'b0;

    always @(posedge clk) begin
        logic [7:0] nled;
        cyc = cyc + 1;
        if (rst) begin
            m_a = 8'h00; m_b = 8'h00; m_op = 6'h00; m_led = 8'h00;
            m_loaded = 3'b000;
            loads.delete();
        end else begin
            nled = alu_f(m_a, m_b, m_op);
            while (loads.size() > 0 && loads[0].edge_n == cyc) begin
                if (loads[0].mask[0]) m_a = loads[0].sw;
                if (loads[0].mask[1]) m_b = loads[0].sw;
                if (loads[0].mask[2]) m_op = loads[0].sw[5:0];
                m_loaded = m_loaded | loads[0].mask;
                void'(loads.pop_front());
            end
            m_led = nled;
        end
    end

    always @(negedge clk) begin
        if (sb_en) begin
            checks++;
            if (led !== m_led) begin
                errors++;
                $display("FAIL sb_led cyc %0d got %h exp %h", cyc, led, m_led);
            end
            checks++;
            if ({data_a, data_b, op} !== {m_a, m_b, m_op}) begin
                errors++;
                $display("FAIL sb_regs cyc %0d got %h/%h/%h exp %h/%h/%h",
                         cyc, data_a, data_b, op, m_a, m_b, m_op);
            end
            checks++;
            if (ready !== (&m_loaded)) begin
                errors++;
                $display("FAIL sb_ready cyc %0d got %b exp %b", cyc, ready, &m_loaded);
            end
        end
    end

    task automatic press(input logic [2:0] mask, input logic [7:0] sw,
                         input int hold, input int gap);
        load_t ld;
        @(negedge clk);
        sw_drv = sw;
        {btn_op, btn_b, btn_a} = mask;
        if (hold >= DBNC) begin
            ld.edge_n = cyc + 1 + LAT;
            ld.mask   = mask;
            ld.sw     = sw;
            loads.push_back(ld);
        end
        repeat (hold) @(negedge clk);
        {btn_op, btn_b, btn_a} = 3'b000;
        repeat (gap) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({data_a, data_b, op, led, ready} !== 31'd0) begin
            errors++;
            $display("FAIL reset got a=%h b=%h op=%h led=%h rdy=%b exp all 0",
                     data_a, data_b, op, led, ready);
        end
        rst = 1'b0;
        sb_en = 1'b1;
    endtask

    task automatic test_hold_a();
        int    e0;
        load_t ld;
        @(negedge clk);
        sw_drv = 8'hF6;
        btn_a  = 1'b1;
        e0 = cyc + 1;
        ld.edge_n = e0 + LAT; ld.mask = 3'b001; ld.sw = 8'hF6;
        loads.push_back(ld);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (data_a !== ((cyc >= e0 + LAT) ? 8'hF6 : 8'h00)) begin
                errors++;
                $display("FAIL hold_a edge %0d got %h exp %h", cyc - e0, data_a,
                         (cyc >= e0 + LAT) ? 8'hF6 : 8'h00);
            end
            checks++;
            if ({data_b, op} !== 14'd0) begin
                errors++;
                $display("FAIL hold_a_others got b=%h op=%h exp 0", data_b, op);
            end
            // A repeat load while still held would capture this new value.
            if (cyc == e0 + 9) sw_drv = 8'h11;
        end
        btn_a = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_glitch_b();
        @(negedge clk);
        btn_b = 1'b1;
        repeat (3) @(negedge clk);
        btn_b = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (data_b !== 8'h00) begin
            errors++;
            $display("FAIL glitch_b got %h exp 00", data_b);
        end
        press(3'b010, 8'h03, DBNC, 10);
        checks++;
        if (data_b !== 8'h03) begin
            errors++;
            $display("FAIL hold4_b got %h exp 03", data_b);
        end
    endtask

    task automatic test_sub_ready();
        int    e0;
        load_t ld;
        press(3'b001, 8'h05, 6, 10);
        press(3'b010, 8'h03, 6, 10);
        @(negedge clk);
        sw_drv = 8'hA2;
        btn_op = 1'b1;
        e0 = cyc + 1;
        ld.edge_n = e0 + LAT; ld.mask = 3'b100; ld.sw = 8'hA2;
        loads.push_back(ld);
        while (cyc < e0 + LAT - 1) @(negedge clk);
        checks++;
        if ({op, ready} !== {6'h00, 1'b0}) begin
            errors++;
            $display("FAIL sub_pre got op=%h rdy=%b exp 00/0", op, ready);
        end
        @(negedge clk);
        checks++;
        if ({op, ready, led} !== {6'h22, 1'b1, 8'h00}) begin
            errors++;
            $display("FAIL sub_load got op=%h rdy=%b led=%h exp 22/1/00", op, ready, led);
        end
        @(negedge clk);
        checks++;
        if (led !== 8'h02) begin
            errors++;
            $display("FAIL sub_led got %h exp 02", led);
        end
        btn_op = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_simultaneous();
        int    e0;
        load_t ld;
        @(negedge clk);
        sw_drv = 8'h20;
        {btn_op, btn_a} = 2'b11;
        e0 = cyc + 1;
        ld.edge_n = e0 + LAT; ld.mask = 3'b101; ld.sw = 8'h20;
        loads.push_back(ld);
        while (cyc < e0 + LAT - 1) @(negedge clk);
        checks++;
        if ({data_a, op} !== {8'h05, 6'h22}) begin
            errors++;
            $display("FAIL simul_pre got a=%h op=%h exp 05/22", data_a, op);
        end
        @(negedge clk);
        checks++;
        if ({data_a, op} !== {8'h20, 6'h20}) begin
            errors++;
            $display("FAIL simul_load got a=%h op=%h exp 20/20", data_a, op);
        end
        @(negedge clk);
        checks++;
        if (led !== 8'h23) begin
            errors++;
            $display("FAIL simul_led got %h exp 23", led);
        end
        {btn_op, btn_a} = 2'b00;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int    e1;
        load_t ld;
        @(negedge clk);
        sw_drv = 8'h7E;
        btn_a  = 1'b1;
        // Counter reaches 2 at edge 3; reset is sampled at edge 4.
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        e1 = cyc + 1;
        ld.edge_n = e1 + LAT; ld.mask = 3'b001; ld.sw = 8'h7E;
        loads.push_back(ld);
        while (cyc < e1 + LAT - 1) @(negedge clk);
        checks++;
        if (data_a !== 8'h00) begin
            errors++;
            $display("FAIL rstmid_pre got %h exp 00", data_a);
        end
        @(negedge clk);
        checks++;
        if ({data_a, ready} !== {8'h7E, 1'b0}) begin
            errors++;
            $display("FAIL rstmid_load got a=%h rdy=%b exp 7E/0", data_a, ready);
        end
        btn_a = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_random();
        logic [5:0] ops [8];
        logic [7:0] sw;
        ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};
        for (int i = 0; i < 40; i++) begin
            sw = 8'($urandom);
            if ($urandom_range(0, 1) == 1) sw[5:0] = ops[$urandom_range(0, 7)];
            press(3'($urandom_range(1, 7)), sw, int'($urandom_range(1, 9)),
                  int'($urandom_range(10, 14)));
        end
        repeat (12) @(negedge clk);
        checks++;
        if (loads.size() != 0) begin
            errors++;
            $display("FAIL random_drain got %0d pending exp 0", loads.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        sw_drv = 8'h00;
        btn_a = 1'b0;
        btn_b = 1'b0;
        btn_op = 1'b0;
        test_reset();
        test_hold_a();
        test_glitch_b();
        test_sub_ready();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
